// File: rtl/evm_pkg.sv
// Shared definitions for the EVM tally path: winner-scan FSM encoding and a width helper.
package evm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ceil(log2(n)), never less than 1 so single-candidate builds keep a 1-bit index
    function automatic int CLOG2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mag_compare.sv
// Enabled unsigned magnitude compare of a against b; purely combinational, zero latency.
// All outputs are forced low when en is low; no flow control.
module mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    assign eq = en && (a == b);
    assign gt = en && (a > b);
    assign lt = en && (a < b);

endmodule

// File: rtl/vote_winner_scan.sv
// Snapshots NUM_CAND counts and scans one per cycle for the lowest-index maximum; done NUM_CAND cycles after start.
// enable low stalls the scan in place; start is ignored while busy.
module vote_winner_scan
    import evm_pkg::*;
#(
    parameter int  WIDTH    = 8,
    parameter int  NUM_CAND = 4,
    localparam int IDX_W    = CLOG2(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      enable,
    input  logic [NUM_CAND*WIDTH-1:0] counts_in,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          winner_idx,
    output logic [WIDTH-1:0]          winner_count,
    output logic                      tie,
    output logic                      no_votes
);

    localparam int              PTR_W    = IDX_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CAND - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   snap_q [NUM_CAND];
    logic [WIDTH-1:0]   snap_d [NUM_CAND];
    logic [WIDTH-1:0]   max_q, max_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tie_w_q, tie_w_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   win_idx_q, win_idx_d;
    logic [WIDTH-1:0]   win_cnt_q, win_cnt_d;
    logic               tie_q, tie_d;
    logic               nov_q, nov_d;

    logic [WIDTH-1:0]   cur_cnt;
    logic               cmp_eq, cmp_gt, cmp_lt;
    logic               step;

    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (ptr_q == PTR_W'(i)) cur_cnt = snap_q[i];
        end
    end

    mag_compare #(.WIDTH(WIDTH)) u_cmp (
        .en (state_q == ST_SCAN && enable),
        .a  (cur_cnt),
        .b  (max_q),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    // Exactly one relation is reported whenever the comparator is enabled.
    assign step = cmp_gt | cmp_eq | cmp_lt;

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        max_d     = max_q;
        idx_d     = idx_q;
        tie_w_d   = tie_w_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_cnt_d = win_cnt_q;
        tie_d     = tie_q;
        nov_d     = nov_q;

        case (state_q)
            ST_IDLE: begin
                if (start && enable) begin
                    for (int i = 0; i < NUM_CAND; i++) snap_d[i] = counts_in[i*WIDTH +: WIDTH];
                    max_d   = counts_in[WIDTH-1:0];
                    idx_d   = '0;
                    tie_w_d = 1'b0;
                    ptr_d   = PTR_W'(1);
                    state_d = (NUM_CAND == 1) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (step) begin
                    if (cmp_gt) begin
                        max_d   = cur_cnt;
                        idx_d   = ptr_q[IDX_W-1:0];
                        tie_w_d = 1'b0;
                    end else if (cmp_eq) begin
                        tie_w_d = 1'b1;
                    end
                    ptr_d = ptr_q + PTR_W'(1);
                    if (ptr_q == LAST_PTR) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Results are published only on the edge into DONE so they hold steady during a scan.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            win_idx_d = idx_d;
            win_cnt_d = max_d;
            tie_d     = tie_w_d;
            nov_d     = (max_d == '0);
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            tie_w_q   <= 1'b0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_idx_q <= '0;
            win_cnt_q <= '0;
            tie_q     <= 1'b0;
            nov_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            tie_w_q   <= tie_w_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            win_idx_q <= win_idx_d;
            win_cnt_q <= win_cnt_d;
            tie_q     <= tie_d;
            nov_q     <= nov_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign winner_idx   = win_idx_q;
    assign winner_count = win_cnt_q;
    assign tie          = tie_q;
    assign no_votes     = nov_q;

endmodule
